// File: rtl/fft1024_pkg.sv
// Shared constants for the 1024-point FFT and the quarter-wave cosine generator.
// The FFT core reuses qwave_val() to build its reference twiddles.
package fft1024_pkg;

  localparam int N          = 1024;
  localparam int LOG2N      = 10;
  localparam int TWID_SCALE = 32767;
  localparam int DATA_W     = 16;
  localparam int QTAB_LEN   = N / 4 + 1;

  // Q[m] = round(32767*cos(2*pi*m/N)), m = 0..N/4; never negative, so +0.5 then truncate
  // is round-half-away-from-zero.
  function automatic logic [DATA_W-2:0] qwave_val(input int m);
    real r_pi;
    real r_val;
    r_pi  = 3.14159265358979323846;
    r_val = real'(TWID_SCALE) * $cos(2.0 * r_pi * real'(m) / real'(N));
    return (DATA_W-1)'($rtoi(r_val + 0.5));
  endfunction

endpackage

// File: rtl/fft1024_qrom.sv
// Quarter-wave cosine ROM (257 x 15) with two asynchronous read ports.
// Port A serves Q[m], port B serves Q[256-m].
module fft1024_qrom
  import fft1024_pkg::*;
(
  input  logic [8:0]        i_addr_a,
  input  logic [8:0]        i_addr_b,
  output logic [DATA_W-2:0] o_q_a,
  output logic [DATA_W-2:0] o_q_b
);

  logic [DATA_W-2:0] w_rom [0:QTAB_LEN-1];

  // Each entry is folded to a constant at elaboration.
  for (genvar g = 0; g < QTAB_LEN; g++) begin : g_rom
    localparam logic [DATA_W-2:0] P_VAL = qwave_val(g);
    assign w_rom[g] = P_VAL;
  end

  assign o_q_a = w_rom[i_addr_a];
  assign o_q_b = w_rom[i_addr_b];

endmodule

// File: rtl/fft1024_lut.sv
// Twiddle ROM: W^n = exp(-j*2*pi*n/1024) as {re, im} Q1.15 words scaled by 32767.
// Built from a quarter-wave table plus exact quadrant negation.
module fft1024_lut #(
  parameter int N       = 1024,
  parameter bit REG_OUT = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  n,
  output logic [31:0] twiddle
);

  import fft1024_pkg::*;

  logic [1:0]        w_quad;
  logic [8:0]        w_addr_m;
  logic [8:0]        w_addr_mc;
  logic [DATA_W-2:0] w_q_m;
  logic [DATA_W-2:0] w_q_mc;
  logic [DATA_W-1:0] w_pos_m;
  logic [DATA_W-1:0] w_pos_mc;
  logic [DATA_W-1:0] w_re;
  logic [DATA_W-1:0] w_im;
  logic [31:0]       w_tw;

  assign w_quad    = n[9:8];
  assign w_addr_m  = {1'b0, n[7:0]};
  assign w_addr_mc = 9'd256 - w_addr_m;

  fft1024_qrom u_qrom (
    .i_addr_a (w_addr_m),
    .i_addr_b (w_addr_mc),
    .o_q_a    (w_q_m),
    .o_q_b    (w_q_mc)
  );

  assign w_pos_m  = {1'b0, w_q_m};
  assign w_pos_mc = {1'b0, w_q_mc};

  // Magnitudes are <= 32767, so two's-complement negation is exact and -0 stays +0.
  always_comb begin
    w_re = w_pos_m;
    w_im = -w_pos_mc;
    case (w_quad)
      2'd0: begin w_re = w_pos_m;   w_im = -w_pos_mc; end
      2'd1: begin w_re = -w_pos_mc; w_im = -w_pos_m;  end
      2'd2: begin w_re = -w_pos_m;  w_im = w_pos_mc;  end
      2'd3: begin w_re = w_pos_mc;  w_im = w_pos_m;   end
      default: ;
    endcase
  end

  assign w_tw = {w_re, w_im};

  if (REG_OUT) begin : g_reg
    logic [31:0] r_tw;
    // Reset value is W^0 so downstream multipliers see unity gain, not zero.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_tw <= 32'h7FFF_0000;
      else       r_tw <= w_tw;
    end
    assign twiddle = r_tw;
  end else begin : g_comb
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = Clk ^ Reset;
    assign twiddle = w_tw;
  end

endmodule

// File: tb/tb_fft1024_lut.sv
// Bench for fft1024_lut: combinational instance checked against fixed vectors and a
// real-valued model over all indices; registered instance checked through a scoreboard.
module tb_fft1024_lut;

  logic        Clk;
  logic        Reset;
  logic [9:0]  n0;
  logic [9:0]  n1;
  logic [31:0] tw0;
  logic [31:0] tw1;

  int n_cmp;
  int n_bad;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [9:0]  n;
    logic [31:0] tw;
    string       name;
  } vec_t;

  vec_t vecs[7];

  fft1024_lut #(.N(1024), .REG_OUT(1'b0)) u_dut_comb (
    .Clk     (Clk),
    .Reset   (Reset),
    .n       (n0),
    .twiddle (tw0)
  );

  fft1024_lut #(.N(1024), .REG_OUT(1'b1)) u_dut_reg (
    .Clk     (Clk),
    .Reset   (Reset),
    .n       (n1),
    .twiddle (tw1)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int round_away(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  // Direct formula on the full circle, independent of any quadrant folding.
  function automatic logic [31:0] model_tw(input logic [9:0] idx);
    real         ang;
    int          re_i;
    int          im_i;
    logic [15:0] re_w;
    logic [15:0] im_w;
    ang  = 2.0 * 3.14159265358979323846 * real'(idx) / 1024.0;
    re_i = round_away(32767.0 * $cos(ang));
    im_i = -round_away(32767.0 * $sin(ang));
    re_w = 16'(re_i);
    im_w = 16'(im_i);
    return {re_w, im_w};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
    end
  endtask

  // registered-path driver: push on drive, pop after the edge, then wiggle n mid-cycle
  task automatic drive_reg(input logic [9:0] nv);
    logic [31:0] exp_v;
    @(negedge Clk);
    n1 = nv;
    exp_q.push_back(model_tw(nv));
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL reg_sb_empty: got no expected entry required one");
    end else begin
      exp_v = exp_q.pop_front();
      check($sformatf("reg_n%0d", nv), tw1, exp_v);
      n1 = 10'($urandom_range(0, 1023));
      #2;
      check($sformatf("reg_hold_n%0d", nv), tw1, exp_v);
    end
  endtask

  initial begin
    logic [15:0] re_s [1024];
    logic [9:0]  nv;
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{10'd0,   32'h7FFF_0000, "n0"};
    vecs[1] = '{10'd256, 32'h0000_8001, "n256"};
    vecs[2] = '{10'd512, 32'h8001_0000, "n512"};
    vecs[3] = '{10'd768, 32'h0000_7FFF, "n768"};
    vecs[4] = '{10'd128, 32'h5A82_A57E, "n128"};
    vecs[5] = '{10'd1,   32'h7FFE_FF37, "n1"};
    vecs[6] = '{10'd511, 32'h8002_FF37, "n511"};

    Reset = 1'b1;
    n0    = 10'd0;
    n1    = 10'd300;
    #2;
    check("reset_state", tw1, 32'h7FFF_0000);
    @(posedge Clk);
    #1;
    check("reset_hold_edge", tw1, 32'h7FFF_0000);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      n0 = vecs[i].n;
      #1;
      check(vecs[i].name, tw0, vecs[i].tw);
    end

    for (int i = 0; i < 1024; i++) begin
      n0 = 10'(i);
      #1;
      check($sformatf("sweep_n%0d", i), tw0, model_tw(10'(i)));
      re_s[i] = tw0[31:16];
      check($sformatf("no_min_re_n%0d", i), {31'd0, tw0[31:16] == 16'h8000}, 32'd0);
      check($sformatf("no_min_im_n%0d", i), {31'd0, tw0[15:0] == 16'h8000}, 32'd0);
    end
    for (int i = 0; i < 512; i++)
      check($sformatf("sym_n%0d", i), {16'd0, re_s[i + 512]}, {16'd0, -re_s[i]});

    drive_reg(10'd0);
    drive_reg(10'd256);
    drive_reg(10'd511);
    drive_reg(10'd1023);
    for (int i = 0; i < 20; i++) drive_reg(10'($urandom_range(0, 1023)));

    // mid-sweep reset: output must jump to W^0 before any edge
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    n1    = 10'd77;
    exp_q.delete();
    #1;
    check("rst_async", tw1, 32'h7FFF_0000);
    @(posedge Clk);
    #1;
    check("rst_hold", tw1, 32'h7FFF_0000);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_release_pre_edge", tw1, 32'h7FFF_0000);
    drive_reg(10'd77);

    for (int i = 0; i < 20; i++) begin
      nv = 10'($urandom_range(0, 1023));
      drive_reg(nv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
